// File: rtl/lab4_branch_bimodal_pht_if.sv
// Prediction, update and control-unit handshake bundle for the bimodal PHT datapath.
// The slave side is the datapath; the master side is its environment (fetch, resolve, control).
interface lab4_branch_bimodal_pht_if;
  logic        pred_req_val;
  logic        pred_req_rdy;
  logic [31:0] pred_req_pc;
  logic        pred_resp_val;
  logic        pred_resp_rdy;
  logic        pred_resp_taken;
  logic        upd_req_val;
  logic        upd_req_rdy;
  logic [31:0] upd_req_pc;
  logic        upd_req_taken;
  logic        update_en;
  logic        update_val;
  logic        entry_upper_reached;
  logic        entry_lower_reached;
  logic        increment_entry;
  logic        decrement_entry;

  modport slave (
    input  pred_req_val, pred_req_pc, pred_resp_rdy,
    input  upd_req_val, upd_req_pc, upd_req_taken,
    input  increment_entry, decrement_entry,
    output pred_req_rdy, pred_resp_val, pred_resp_taken, upd_req_rdy,
    output update_en, update_val, entry_upper_reached, entry_lower_reached
  );

  modport master (
    output pred_req_val, pred_req_pc, pred_resp_rdy,
    output upd_req_val, upd_req_pc, upd_req_taken,
    output increment_entry, decrement_entry,
    input  pred_req_rdy, pred_resp_val, pred_resp_taken, upd_req_rdy,
    input  update_en, update_val, entry_upper_reached, entry_lower_reached
  );
endinterface

// File: rtl/lab4_branch_bimodal_pht.sv
// Bimodal pattern history table: 2-bit counters, buffered 1-cycle predictions and a
// two-state read-modify-write update driven by an external control unit.
module lab4_branch_bimodal_pht #(
  parameter int unsigned PHT_size = 2048
) (
  input logic                          clk,
  input logic                          reset,
  lab4_branch_bimodal_pht_if.slave     bus
);

  localparam int unsigned IDX_BITS = $clog2(PHT_size);

  typedef enum logic [0:0] {StIdle, StUpdate} state_e;

  logic [1:0]          pht_q [PHT_size];
  logic                pht_we;
  logic [1:0]          pht_wdata;

  state_e              state_q, state_d;
  logic [IDX_BITS-1:0] upd_idx_q, upd_idx_d;
  logic                upd_taken_q, upd_taken_d;
  logic [1:0]          upd_cnt_q, upd_cnt_d;

  logic                buf_full_q, buf_full_d;
  logic                buf_taken_q, buf_taken_d;

  logic [IDX_BITS-1:0] pred_idx;
  logic [IDX_BITS-1:0] upd_idx;
  logic                pred_fire;
  logic                pred_drain;

  assign pred_idx = bus.pred_req_pc[IDX_BITS+1:2];
  assign upd_idx  = bus.upd_req_pc[IDX_BITS+1:2];

  // Upper PC bits alias by design; byte offset is irrelevant.
  logic unused_pc;
  assign unused_pc = ^{bus.pred_req_pc[31:IDX_BITS+2], bus.pred_req_pc[1:0],
                       bus.upd_req_pc[31:IDX_BITS+2], bus.upd_req_pc[1:0]};

  // Prediction path: one-entry response buffer.
  assign bus.pred_req_rdy    = !buf_full_q || bus.pred_resp_rdy;
  assign pred_fire           = bus.pred_req_val && bus.pred_req_rdy;
  assign pred_drain          = buf_full_q && bus.pred_resp_rdy;
  assign bus.pred_resp_val   = buf_full_q;
  assign bus.pred_resp_taken = buf_taken_q;

  always_comb begin
    buf_full_d  = buf_full_q;
    buf_taken_d = buf_taken_q;
    if (pred_fire) begin
      buf_full_d  = 1'b1;
      buf_taken_d = pht_q[pred_idx][1];
    end else if (pred_drain) begin
      buf_full_d  = 1'b0;
    end
  end

  // Update FSM next state and latched operands.
  always_comb begin
    state_d     = state_q;
    upd_idx_d   = upd_idx_q;
    upd_taken_d = upd_taken_q;
    upd_cnt_d   = upd_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.upd_req_val) begin
          state_d     = StUpdate;
          upd_idx_d   = upd_idx;
          upd_taken_d = bus.upd_req_taken;
          upd_cnt_d   = pht_q[upd_idx];
        end
      end
      StUpdate: state_d = StIdle;
    endcase
  end

  // Datapath refuses to wrap even if the control unit asks it to.
  always_comb begin
    pht_we    = 1'b0;
    pht_wdata = upd_cnt_q;
    if (state_q == StUpdate) begin
      if (bus.increment_entry && !bus.decrement_entry && upd_cnt_q != 2'b11) begin
        pht_we    = 1'b1;
        pht_wdata = upd_cnt_q + 2'd1;
      end else if (bus.decrement_entry && !bus.increment_entry && upd_cnt_q != 2'b00) begin
        pht_we    = 1'b1;
        pht_wdata = upd_cnt_q - 2'd1;
      end
    end
  end

  assign bus.upd_req_rdy         = (state_q == StIdle);
  assign bus.update_en           = (state_q == StUpdate);
  assign bus.update_val          = (state_q == StUpdate) && upd_taken_q;
  assign bus.entry_upper_reached = (state_q == StUpdate) && (upd_cnt_q == 2'b11);
  assign bus.entry_lower_reached = (state_q == StUpdate) && (upd_cnt_q == 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      upd_idx_q   <= '0;
      upd_taken_q <= 1'b0;
      upd_cnt_q   <= 2'b00;
      buf_full_q  <= 1'b0;
      buf_taken_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      upd_idx_q   <= upd_idx_d;
      upd_taken_q <= upd_taken_d;
      upd_cnt_q   <= upd_cnt_d;
      buf_full_q  <= buf_full_d;
      buf_taken_q <= buf_taken_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(PHT_size); i++) begin
        pht_q[i] <= 2'b01;
      end
    end else if (pht_we) begin
      pht_q[upd_idx_q] <= pht_wdata;
    end
  end

endmodule

// File: tb/tb_lab4_branch_bimodal_pht.sv
// Directed bench for the bimodal PHT datapath; the bench plays the control unit,
// driving increment/decrement from a hand-computed vector table.
module tb_lab4_branch_bimodal_pht;

  localparam int unsigned PhtSize = 2048;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  lab4_branch_bimodal_pht_if bus ();

  lab4_branch_bimodal_pht #(.PHT_size(PhtSize)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] upd_pc;
    logic        taken;
    logic        inc;
    logic        dec;
    logic        exp_upper;
    logic        exp_lower;
    logic [31:0] pred_pc;
    logic        exp_pred;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic predict(input string name, input logic [31:0] pc, input logic exp);
    bus.pred_req_val = 1'b1;
    bus.pred_req_pc  = pc;
    tick();
    bus.pred_req_val = 1'b0;
    check({name, " resp_val"}, {31'd0, bus.pred_resp_val}, 32'd1);
    check({name, " taken"}, {31'd0, bus.pred_resp_taken}, {31'd0, exp});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.pred_req_val    = 1'b0;
    bus.pred_req_pc     = '0;
    bus.pred_resp_rdy   = 1'b1;
    bus.upd_req_val     = 1'b0;
    bus.upd_req_pc      = '0;
    bus.upd_req_taken   = 1'b0;
    bus.increment_entry = 1'b0;
    bus.decrement_entry = 1'b0;

    // upd_pc, taken, inc, dec, upper, lower, pred_pc, pred
    vecs[0]  = '{32'h100,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 1'b1}; // 1->2
    vecs[1]  = '{32'h100,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 1'b1}; // 2->3
    vecs[2]  = '{32'h100,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 1'b1}; // hold 3
    vecs[3]  = '{32'h100,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 1'b1}; // refuse +1 at 3
    vecs[4]  = '{32'h204,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h204, 1'b0}; // 1->0
    vecs[5]  = '{32'h204,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h204, 1'b0}; // hold 0
    vecs[6]  = '{32'h204,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h204, 1'b0}; // refuse -1 at 0
    vecs[7]  = '{32'h2204, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h204, 1'b0}; // alias 0->1
    vecs[8]  = '{32'h2204, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h204, 1'b1}; // alias 1->2
    vecs[9]  = '{32'h204,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h2204, 1'b1}; // both: hold 2
    vecs[10] = '{32'h204,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h204, 1'b0}; // 2->1

    reset = 1'b0;
    #12;
    check("reset pred_resp_val", {31'd0, bus.pred_resp_val}, 32'd0);
    check("reset update_en", {31'd0, bus.update_en}, 32'd0);
    check("reset reached", {30'd0, bus.entry_upper_reached, bus.entry_lower_reached}, 32'd0);
    reset = 1'b1;
    tick();
    check("idle upd_req_rdy", {31'd0, bus.upd_req_rdy}, 32'd1);
    check("idle pred_req_rdy", {31'd0, bus.pred_req_rdy}, 32'd1);

    predict("reset predict 0x100", 32'h100, 1'b0);
    tick();
    check("drained resp_val", {31'd0, bus.pred_resp_val}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      bus.upd_req_val   = 1'b1;
      bus.upd_req_pc    = vecs[i].upd_pc;
      bus.upd_req_taken = vecs[i].taken;
      tick();
      bus.upd_req_val = 1'b0;
      check($sformatf("v%0d update_en", i), {31'd0, bus.update_en}, 32'd1);
      check($sformatf("v%0d upd_req_rdy", i), {31'd0, bus.upd_req_rdy}, 32'd0);
      check($sformatf("v%0d update_val", i), {31'd0, bus.update_val}, {31'd0, vecs[i].taken});
      check($sformatf("v%0d upper", i), {31'd0, bus.entry_upper_reached},
            {31'd0, vecs[i].exp_upper});
      check($sformatf("v%0d lower", i), {31'd0, bus.entry_lower_reached},
            {31'd0, vecs[i].exp_lower});
      bus.increment_entry = vecs[i].inc;
      bus.decrement_entry = vecs[i].dec;
      tick();
      bus.increment_entry = 1'b0;
      bus.decrement_entry = 1'b0;
      check($sformatf("v%0d back to idle", i), {31'd0, bus.update_en}, 32'd0);
      check($sformatf("v%0d reached idle", i),
            {30'd0, bus.entry_upper_reached, bus.entry_lower_reached}, 32'd0);
      predict($sformatf("v%0d predict", i), vecs[i].pred_pc, vecs[i].exp_pred);
      tick();
    end

    // Backpressure: 0x100 holds 3 (taken), 0x204 holds 1 (not taken).
    bus.pred_resp_rdy = 1'b0;
    bus.pred_req_val  = 1'b1;
    bus.pred_req_pc   = 32'h100;
    tick();
    bus.pred_req_pc = 32'h204;
    check("bp first val", {31'd0, bus.pred_resp_val}, 32'd1);
    check("bp first taken", {31'd0, bus.pred_resp_taken}, 32'd1);
    check("bp req_rdy low", {31'd0, bus.pred_req_rdy}, 32'd0);
    tick();
    check("bp held val", {31'd0, bus.pred_resp_val}, 32'd1);
    check("bp held taken", {31'd0, bus.pred_resp_taken}, 32'd1);
    bus.pred_resp_rdy = 1'b1;
    #1;
    check("bp req_rdy on drain", {31'd0, bus.pred_req_rdy}, 32'd1);
    tick();
    bus.pred_req_val = 1'b0;
    check("bp second val", {31'd0, bus.pred_resp_val}, 32'd1);
    check("bp second taken", {31'd0, bus.pred_resp_taken}, 32'd0);
    tick();
    check("bp empty", {31'd0, bus.pred_resp_val}, 32'd0);

    // Async reset in the middle of an UPDATE cycle on 0x100 (counter 3).
    predict("pre-reset 0x100 buffered", 32'h100, 1'b1);
    bus.upd_req_val   = 1'b1;
    bus.upd_req_pc    = 32'h100;
    bus.upd_req_taken = 1'b1;
    tick();
    bus.upd_req_val = 1'b0;
    check("rst mid update_en", {31'd0, bus.update_en}, 32'd1);
    check("rst mid upper", {31'd0, bus.entry_upper_reached}, 32'd1);
    bus.increment_entry = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("async clr update_en", {31'd0, bus.update_en}, 32'd0);
    check("async clr update_val", {31'd0, bus.update_val}, 32'd0);
    check("async clr upper", {31'd0, bus.entry_upper_reached}, 32'd0);
    check("async clr resp_val", {31'd0, bus.pred_resp_val}, 32'd0);
    check("async clr resp_taken", {31'd0, bus.pred_resp_taken}, 32'd0);
    bus.increment_entry = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    predict("post-reset 0x100", 32'h100, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
